// File: rtl/ternary_cam_controller_if.sv
// ---------------------------------------------------------------------------
// ternary_cam_controller_if
//
// Purpose: bundles the request/response handshakes and the TCAM drive of the
// ternary CAM controller so that they travel as one port.
//
// Signal groups:
//   upd_*   update requests (write / invalidate one entry), valid/ready
//   lkp_*   masked lookup requests (mask bit 1 = don't care), valid/ready
//   res_*   lookup results (hit, lowest matching address, multi-hit)
//   tcam_*  drive towards the TCAM plus its combinational match vector
//
// Modports:
//   slave   the controller side (consumes requests, drives results and TCAM)
//   master  the requester / TCAM side (drives requests, sinks results)
// ---------------------------------------------------------------------------
interface ternary_cam_controller_if #(
  parameter int word_size    = 8,
  parameter int address_size = 4
);
  localparam int depth = 1 << address_size;

  // update channel
  logic                    upd_valid;
  logic                    upd_ready;
  logic                    upd_op;
  logic [address_size-1:0] upd_address;
  logic [word_size-1:0]    upd_word;

  // lookup channel
  logic                    lkp_valid;
  logic                    lkp_ready;
  logic [word_size-1:0]    lkp_word;
  logic [word_size-1:0]    lkp_mask;

  // result channel
  logic                    res_valid;
  logic                    res_ready;
  logic                    res_hit;
  logic [address_size-1:0] res_address;
  logic                    res_multi;

  // TCAM port
  logic [word_size-1:0]    tcam_word;
  logic [word_size-1:0]    tcam_mask;
  logic [address_size-1:0] tcam_address;
  logic                    tcam_write;
  logic [depth-1:0]        tcam_matched;

  modport slave (
    input  upd_valid, upd_op, upd_address, upd_word,
    output upd_ready,
    input  lkp_valid, lkp_word, lkp_mask,
    output lkp_ready,
    output res_valid, res_hit, res_address, res_multi,
    input  res_ready,
    output tcam_word, tcam_mask, tcam_address, tcam_write,
    input  tcam_matched
  );

  modport master (
    output upd_valid, upd_op, upd_address, upd_word,
    input  upd_ready,
    output lkp_valid, lkp_word, lkp_mask,
    input  lkp_ready,
    input  res_valid, res_hit, res_address, res_multi,
    output res_ready,
    input  tcam_word, tcam_mask, tcam_address, tcam_write,
    output tcam_matched
  );

endinterface

// File: rtl/ternary_cam_controller.sv
// ---------------------------------------------------------------------------
// ternary_cam_controller
//
// Purpose: sequencing and arbitration front-end for a single-port ternary CAM.
// Two independent requesters (entry updates and masked lookups) are
// round-robin arbitrated and serialised onto the TCAM port. The controller
// keeps the per-entry valid bitmap the TCAM itself lacks and priority-encodes
// the lookup result (lowest matching valid address wins).
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous, active-low reset
//   bus          ternary_cam_controller_if.slave: upd/lkp/res handshakes and
//                TCAM drive (tcam_word/mask/address/write, tcam_matched)
//   busy         high whenever the sequencer is not idle
//   hit_count    (TCAM_CTRL_STATS_EN only) saturating count of hit results
//   miss_count   (TCAM_CTRL_STATS_EN only) saturating count of miss results
//
// Configuration:
//   TCAM_CTRL_STATS_EN  when defined, adds the hit/miss statistics counters
//                       and their output ports. Undefined by default.
// ---------------------------------------------------------------------------
module ternary_cam_controller #(
  parameter int word_size    = 8,
  parameter int address_size = 4
) (
  input  logic                            clock,
  input  logic                            reset,
  ternary_cam_controller_if.slave         bus,
  output logic                            busy
`ifdef TCAM_CTRL_STATS_EN
  ,
  output logic [15:0]                     hit_count,
  output logic [15:0]                     miss_count
`endif
);

  localparam int depth = 1 << address_size;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    SEARCH = 2'd2,
    RESULT = 2'd3
  } state_t;

  // Encoding of the round-robin memory: which requester won last.
  localparam logic GRANT_UPD = 1'b0;
  localparam logic GRANT_LKP = 1'b1;

  state_t                  state_q, state_d;
  logic                    last_grant_q, last_grant_d;
  logic                    op_q, op_d;
  logic [address_size-1:0] addr_q, addr_d;
  logic [word_size-1:0]    word_q, word_d;
  logic [word_size-1:0]    mask_q, mask_d;
  logic [depth-1:0]        valid_q, valid_d;
  logic [depth-1:0]        hit_q, hit_d;

  logic                    grant_upd;
  logic                    grant_lkp;
  logic                    upd_fire;
  logic                    lkp_fire;
  logic                    res_fire;
  logic [address_size-1:0] first_hit;
  logic                    multi_hit;

  // Arbitration. Grants are only offered while idle, and only to a requester
  // that is actually asking, so at most one ready is high in any cycle. On a
  // tie the requester that did not win last time gets the slot.
  always_comb begin
    grant_upd = 1'b0;
    grant_lkp = 1'b0;
    if (state_q == IDLE) begin
      if (bus.upd_valid && bus.lkp_valid) begin
        grant_upd = (last_grant_q == GRANT_LKP);
        grant_lkp = (last_grant_q == GRANT_UPD);
      end else begin
        grant_upd = bus.upd_valid;
        grant_lkp = bus.lkp_valid;
      end
    end
  end

  assign bus.upd_ready = grant_upd;
  assign bus.lkp_ready = grant_lkp;

  assign upd_fire = bus.upd_valid && grant_upd;
  assign lkp_fire = bus.lkp_valid && grant_lkp;
  assign res_fire = bus.res_valid && bus.res_ready;

  // Sequencer next-state logic. Request fields are captured on the accepting
  // edge and then drive the TCAM directly from their registers, which is why
  // the TCAM outputs simply hold their values outside the UPDATE/SEARCH slots.
  // An update always presents an all-zero mask so the stored entry is exact.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    addr_d       = addr_q;
    word_d       = word_q;
    mask_d       = mask_q;
    valid_d      = valid_q;
    hit_d        = hit_q;

    case (state_q)
      IDLE: begin
        if (upd_fire) begin
          state_d      = UPDATE;
          last_grant_d = GRANT_UPD;
          op_d         = bus.upd_op;
          addr_d       = bus.upd_address;
          word_d       = bus.upd_word;
          mask_d       = '0;
        end else if (lkp_fire) begin
          state_d      = SEARCH;
          last_grant_d = GRANT_LKP;
          word_d       = bus.lkp_word;
          mask_d       = bus.lkp_mask;
        end
      end

      // The valid bit changes on the same edge that the TCAM write lands, so
      // a lookup granted right afterwards already sees the new entry.
      UPDATE: begin
        valid_d[addr_q] = op_q;
        state_d         = IDLE;
      end

      // Entries the TCAM still matches but that were invalidated (or never
      // written since reset) are filtered out here.
      SEARCH: begin
        hit_d   = bus.tcam_matched & valid_q;
        state_d = RESULT;
      end

      RESULT: begin
        if (res_fire) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset drops any in-flight request and
  // invalidates every entry; the TCAM contents are left alone and stay
  // unmatched until rewritten because their valid bits are clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_LKP;
      op_q         <= 1'b0;
      addr_q       <= '0;
      word_q       <= '0;
      mask_q       <= '0;
      valid_q      <= '0;
      hit_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      word_q       <= word_d;
      mask_q       <= mask_d;
      valid_q      <= valid_d;
      hit_q        <= hit_d;
    end
  end

  // Priority encoder: scanning from the top down lets the lowest set index
  // be the last assignment, so it wins. No hit leaves the address at 0.
  always_comb begin
    first_hit = '0;
    for (int i = depth - 1; i >= 0; i--) begin
      if (hit_q[i]) begin
        first_hit = address_size'(i);
      end
    end
  end

  // Clearing the lowest set bit leaves something behind only when two or
  // more bits were set, which is exactly popcount > 1.
  assign multi_hit = |(hit_q & (hit_q - {{(depth - 1){1'b0}}, 1'b1}));

  // The result payload reflects the last completed search and is therefore
  // stable for as long as RESULT waits on res_ready.
  assign bus.res_valid   = (state_q == RESULT);
  assign bus.res_hit     = |hit_q;
  assign bus.res_address = first_hit;
  assign bus.res_multi   = multi_hit;

  assign bus.tcam_write   = (state_q == UPDATE) && op_q;
  assign bus.tcam_word    = word_q;
  assign bus.tcam_mask    = mask_q;
  assign bus.tcam_address = addr_q;

  assign busy = (state_q != IDLE);

`ifdef TCAM_CTRL_STATS_EN
  logic [15:0] hit_count_q, hit_count_d;
  logic [15:0] miss_count_q, miss_count_d;

  // Statistics count completed result handshakes only, so a lookup dropped
  // by reset is never counted. Both counters stick at all-ones.
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (res_fire) begin
      if (bus.res_hit) begin
        if (hit_count_q != 16'hFFFF) begin
          hit_count_d = hit_count_q + 16'd1;
        end
      end else begin
        if (miss_count_q != 16'hFFFF) begin
          miss_count_d = miss_count_q + 16'd1;
        end
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`else
  // Statistics disabled: no counters and no extra ports are built.
`endif

endmodule
